// File: rtl/button_conditioner_if.sv
// Button bundle between the raw board buttons and the conditioner.
// The master drives raw buttons; the slave returns clean level and pulse.
interface button_conditioner_if;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_pulse
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: sync, debounce, press pulse and auto-repeat.
// Four independent channels, {btnD, btnR, btnL, btnU} on bits [3:0].
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 10000000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b1001
) (
    input logic                  clk,
    input logic                  rst,
    button_conditioner_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        HELD,
        REPEAT,
        DISARM
    } state_t;

    localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RR_LAST  = 32'(REPEAT_RATE - 1);
    localparam logic [31:0] CNT_MAX  = '1;

    logic [3:0] level_w;
    logic [3:0] pulse_w;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        localparam logic RPT_EN = REPEAT_MASK[i];

        logic [1:0]  sync_q;
        logic        sync;
        state_t      state;
        logic [31:0] cnt;
        logic        level_q;
        logic        pulse_q;

        assign sync = sync_q[1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q  <= 2'b00;
                state   <= IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                sync_q  <= {sync_q[0], bus.btn_in[i]};
                pulse_q <= 1'b0;
                cnt     <= cnt + 32'd1;
                unique case (state)
                    IDLE: begin
                        if (sync) begin
                            state <= ARM;
                            cnt   <= '0;
                        end
                    end
                    ARM: begin
                        if (!sync) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state   <= HELD;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            pulse_q <= 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sync) begin
                            state <= DISARM;
                            cnt   <= '0;
                        end else if (RPT_EN && cnt == RD_LAST) begin
                            state   <= REPEAT;
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end else if (!RPT_EN && cnt == CNT_MAX) begin
                            // long holds on non-repeat keys must not wrap
                            cnt <= cnt;
                        end
                    end
                    REPEAT: begin
                        if (!sync) begin
                            state <= DISARM;
                            cnt   <= '0;
                        end else if (cnt == RR_LAST) begin
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end
                    end
                    DISARM: begin
                        if (sync) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            level_q <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign level_w[i] = level_q;
        assign pulse_w[i] = pulse_q;
    end

    assign bus.btn_level = level_w;
    assign bus.btn_pulse = pulse_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
// Edge e means the e-th rising edge after a scenario starts driving btn_in.
module tb_button_conditioner;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_MASK     (4'b1001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        bus.btn_in = 4'b0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.btn_in = 4'b1111;
        rst = 1'b1;
        #2;
        checks++;
        if (bus.btn_level !== 4'b0000) begin
            errors++;
            $display("FAIL reset_level got=%b exp=%b", bus.btn_level, 4'b0000);
        end
        checks++;
        if (bus.btn_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulse got=%b exp=%b", bus.btn_pulse, 4'b0000);
        end
        do_reset();
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++;
            if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle e=%0d got=%b/%b exp=0000/0000",
                         e, bus.btn_level, bus.btn_pulse);
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [3:0] ep;
        logic [3:0] el;
        do_reset();
        for (int e = 0; e <= 40; e++) begin
            bus.btn_in = (e <= 29) ? 4'b0001 : 4'b0000;
            tick();
            ep = (e == 6 || e == 16 || e == 19 || e == 22 ||
                  e == 25 || e == 28 || e == 31) ? 4'b0001 : 4'b0000;
            el = (e >= 6 && e < 36) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.btn_pulse !== ep) begin
                errors++;
                $display("FAIL hold_pulse e=%0d got=%b exp=%b", e, bus.btn_pulse, ep);
            end
            checks++;
            if (bus.btn_level !== el) begin
                errors++;
                $display("FAIL hold_level e=%0d got=%b exp=%b", e, bus.btn_level, el);
            end
        end
    endtask

    task automatic test_press_bounce();
        do_reset();
        for (int e = 0; e <= 20; e++) begin
            bus.btn_in = (e <= 2) ? 4'b0010 : 4'b0000;
            tick();
            checks++;
            if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL bounce e=%0d got=%b/%b exp=0000/0000",
                         e, bus.btn_level, bus.btn_pulse);
            end
        end
    endtask

    task automatic test_no_repeat();
        logic [3:0] ep;
        logic [3:0] el;
        do_reset();
        for (int e = 0; e <= 50; e++) begin
            bus.btn_in = (e <= 39) ? 4'b0100 : 4'b0000;
            tick();
            ep = (e == 6) ? 4'b0100 : 4'b0000;
            el = (e >= 6 && e < 46) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.btn_pulse !== ep) begin
                errors++;
                $display("FAIL norpt_pulse e=%0d got=%b exp=%b", e, bus.btn_pulse, ep);
            end
            checks++;
            if (bus.btn_level !== el) begin
                errors++;
                $display("FAIL norpt_level e=%0d got=%b exp=%b", e, bus.btn_level, el);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [3:0] ep;
        logic [3:0] el;
        do_reset();
        for (int e = 0; e <= 36; e++) begin
            bus.btn_in = (e == 12 || e == 13) ? 4'b0000 : 4'b1000;
            tick();
            ep = (e == 6 || e == 26 || e == 29 || e == 32 || e == 35)
                 ? 4'b1000 : 4'b0000;
            el = (e >= 6) ? 4'b1000 : 4'b0000;
            checks++;
            if (bus.btn_pulse !== ep) begin
                errors++;
                $display("FAIL relb_pulse e=%0d got=%b exp=%b", e, bus.btn_pulse, ep);
            end
            checks++;
            if (bus.btn_level !== el) begin
                errors++;
                $display("FAIL relb_level e=%0d got=%b exp=%b", e, bus.btn_level, el);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] ep;
        logic [3:0] el;
        do_reset();
        bus.btn_in = 4'b0001;
        for (int e = 0; e <= 19; e++) tick();
        checks++;
        if (bus.btn_level !== 4'b0001 || bus.btn_pulse !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_pre got=%b/%b exp=0001/0001",
                     bus.btn_level, bus.btn_pulse);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_drop got=%b/%b exp=0000/0000",
                     bus.btn_level, bus.btn_pulse);
        end
        tick();
        rst = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            tick();
            ep = (e == 6) ? 4'b0001 : 4'b0000;
            el = (e >= 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.btn_pulse !== ep || bus.btn_level !== el) begin
                errors++;
                $display("FAIL midrst_post e=%0d got=%b/%b exp=%b/%b",
                         e, bus.btn_level, bus.btn_pulse, el, ep);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ep;
        logic [3:0] el;
        do_reset();
        for (int e = 0; e <= 25; e++) begin
            bus.btn_in = 4'b1001;
            tick();
            ep = (e == 6 || e == 16 || e == 19 || e == 22 || e == 25)
                 ? 4'b1001 : 4'b0000;
            el = (e >= 6) ? 4'b1001 : 4'b0000;
            checks++;
            if (bus.btn_pulse !== ep) begin
                errors++;
                $display("FAIL simul_pulse e=%0d got=%b exp=%b", e, bus.btn_pulse, ep);
            end
            checks++;
            if (bus.btn_level !== el) begin
                errors++;
                $display("FAIL simul_level e=%0d got=%b exp=%b", e, bus.btn_level, el);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.btn_in = 4'b0000;
        test_reset();
        test_hold_repeat();
        test_press_bounce();
        test_no_repeat();
        test_release_bounce();
        test_reset_mid_hold();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input conditioning stage for the board push-buttons (btnU, btnL, btnR, btnD). It synchronises each raw button to the 100 MHz clock and debounces it. It emits a clean level and a one-cycle press pulse per button, with auto-repeat pulses while a repeat-enabled button is held. It sits directly upstream of the 8-bit up/down counter: the counter steps on btn_pulse instead of raw buttons sampled on a slow clock.

## Interface
- DEBOUNCE_CYCLES, 1000000: cycles the synchronised input must stay stable before a change is accepted (10 ms at 100 MHz); minimum 2.
- REPEAT_DELAY, 50000000: cycles from the initial press pulse to the first repeat pulse; minimum 2.
- REPEAT_RATE, 10000000: cycles between subsequent repeat pulses; minimum 2.
- REPEAT_MASK, 4'b1001: per-button auto-repeat enable; default enables U and D only.
- clk  input  1  100 MHz board clock; every register is clocked on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  4  raw buttons, {btnD, btnR, btnL, btnU} = bits [3:0]; asynchronous and bouncing.
- btn_level  output  4  debounced button state, 1 = pressed.
- btn_pulse  output  4  one-cycle strobe on the accepted press and on each auto-repeat.

## Operation
- Four identical, fully independent channels. No cross-button priority here; priority is resolved downstream (R > L > U > D).
- Per channel: 2-flop synchroniser (sync) feeding a 5-state FSM and a 32-bit counter (cnt). cnt clears on every state transition and increments every cycle otherwise.
- IDLE (level 0):
  - sync=1 → ARM.
- ARM (level 0):
  - sync=0 → IDLE, no output.
  - sync=1 and cnt==DEBOUNCE_CYCLES-1 → HELD; level←1; pulse←1.
- HELD (level 1):
  - sync=0 → DISARM.
  - REPEAT_MASK bit set and cnt==REPEAT_DELAY-1 → REPEAT; pulse←1.
  - Mask bit clear → stays in HELD indefinitely; cnt saturates at all-ones instead of wrapping.
- REPEAT (level 1):
  - sync=0 → DISARM.
  - cnt==REPEAT_RATE-1 → pulse←1; cnt←0; state stays REPEAT.
- DISARM (level 1):
  - sync=1 → HELD. No pulse; the repeat delay restarts from 0.
  - sync=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE; level←0. Release produces no pulse.
- Outputs:
  - btn_pulse is registered and high for exactly one cycle per event.
  - btn_level is registered; it is 1 in HELD, REPEAT and DISARM.
- Simultaneous events across channels produce simultaneous pulses.
- Within a channel, the sync value takes precedence over counter expiry, as defined per state above.

## Timing
- Reset:
  - All sync flops, cnt, btn_level and btn_pulse clear to 0; FSMs go to IDLE, asynchronously.
  - First post-reset edge behaves as from IDLE.
- Press latency: btn_in first sampled high at edge 0 (held stable) → btn_level and btn_pulse high after edge DEBOUNCE_CYCLES+2.
- Repeat timing:
  - First repeat pulse comes REPEAT_DELAY cycles after the initial pulse.
  - Each following pulse comes every REPEAT_RATE cycles.
- Release latency: btn_in first sampled low at edge r → btn_level low after edge r+DEBOUNCE_CYCLES+2.
- Glitches:
  - A high glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output.
  - A low glitch shorter than DEBOUNCE_CYCLES while held keeps btn_level at 1.
- Reset mid-press: outputs drop immediately. A button still held after rst deasserts is re-debounced from IDLE and produces a fresh press pulse.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=4'b1001.
- Hold with repeat: btn_in[0] high at sampling edges 0–29, low after → btn_pulse[0] high after edges 6, 16, 19, 22, 25, 28, 31 only; btn_level[0] high after edge 6, low after edge 36.
- Press bounce: btn_in[1] high for 3 edges, then low → btn_level[1] and btn_pulse[1] stay 0 throughout.
- Non-repeat button: btn_in[2] held 40 cycles → exactly one btn_pulse[2] (after edge 6); btn_level[2] high until 6 edges after release.
- Release bounce: btn_in[3] held, low for 2 edges at edge 12, then high again → btn_level[3] stays 1 with no extra pulse; the next repeat pulse is REPEAT_DELAY cycles after re-entering HELD.
- Reset mid-hold: rst pulsed during a btn_in[0] hold at edge 20 → all outputs 0 immediately; after deassert, btn_pulse[0] high 6 edges after the first post-reset sampling edge.
- Simultaneous press: btn_in[0] and btn_in[3] rise on the same edge → both btn_pulse bits assert on the same cycle, including repeats.
